// File: rtl/fifo_ctrl.sv
// Pointer/occupancy controller that runs an external MEM_LENGHT-entry memory as a circular FIFO.
// It decides which push/pop requests are accepted, drives the memory enables and addresses, and decodes the status flags.
module fifo_ctrl #(
  parameter int MEM_WIDTH       = 10,
  parameter int MEM_LENGHT      = 8,
  parameter int ALMOST_FULL_TH  = 6,
  parameter int ALMOST_EMPTY_TH = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  logic       pop,
  output logic       write_enable,
  output logic       read_enable,
  output logic [3:0] write_addr,
  output logic [3:0] read_addr,
  output logic [3:0] count,
  output logic       full,
  output logic       empty,
  output logic       almost_full,
  output logic       almost_empty,
  output logic       error,
  output logic       data_valid
);

  localparam int PW = (MEM_LENGHT > 1) ? $clog2(MEM_LENGHT) : 1;
  localparam int CW = PW + 1;

  if (MEM_WIDTH < 1 || MEM_LENGHT < 2 || MEM_LENGHT > 16 ||
      (MEM_LENGHT & (MEM_LENGHT - 1)) != 0) begin : g_param_check
    $error("fifo_ctrl: MEM_LENGHT must be a power of two in 2..16 and MEM_WIDTH >= 1");
  end

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          error_q, error_d;
  logic          data_valid_q, data_valid_d;

  // Flags decode the registered count only, so push/pop never reach them combinationally.
  assign full         = (count_q == CW'(MEM_LENGHT));
  assign empty        = (count_q == '0);
  assign almost_full  = (count_q >= CW'(ALMOST_FULL_TH));
  assign almost_empty = (count_q <= CW'(ALMOST_EMPTY_TH));

  assign write_enable = push & ~full;
  assign read_enable  = pop & ~empty;

  assign write_addr   = 4'(wr_ptr_q);
  assign read_addr    = 4'(rd_ptr_q);
  assign count        = 4'(count_q);
  assign error        = error_q;
  assign data_valid   = data_valid_q;

  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    error_d      = error_q | (push & full) | (pop & empty);
    data_valid_d = read_enable;

    if (write_enable) wr_ptr_d = wr_ptr_q + PW'(1);
    if (read_enable)  rd_ptr_d = rd_ptr_q + PW'(1);

    case ({write_enable, read_enable})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      error_q      <= 1'b0;
      data_valid_q <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      error_q      <= error_d;
      data_valid_q <= data_valid_d;
    end
  end

endmodule

// File: tb/tb_fifo_ctrl.sv
// Bench for fifo_ctrl: a behavioural 10x8 memory sits beside the controller; popped words are
// scoreboarded against hand-written expected data, and status outputs are checked directly.
module tb_fifo_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       push;
  logic       pop;
  logic       write_enable;
  logic       read_enable;
  logic [3:0] write_addr;
  logic [3:0] read_addr;
  logic [3:0] count;
  logic       full;
  logic       empty;
  logic       almost_full;
  logic       almost_empty;
  logic       error;
  logic       data_valid;

  logic [9:0] din;
  logic [9:0] dout;
  logic [9:0] mem [8];

  int n_checks = 0;
  int n_errors = 0;
  int n_valid  = 0;
  logic [9:0] exp_q [$];

  always #5 clk = ~clk;

  fifo_ctrl #(
    .MEM_WIDTH      (10),
    .MEM_LENGHT     (8),
    .ALMOST_FULL_TH (6),
    .ALMOST_EMPTY_TH(2)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .push        (push),
    .pop         (pop),
    .write_enable(write_enable),
    .read_enable (read_enable),
    .write_addr  (write_addr),
    .read_addr   (read_addr),
    .count       (count),
    .full        (full),
    .empty       (empty),
    .almost_full (almost_full),
    .almost_empty(almost_empty),
    .error       (error),
    .data_valid  (data_valid)
  );

  always @(posedge clk) begin
    if (write_enable) mem[write_addr[2:0]] <= din;
    if (read_enable)  dout <= mem[read_addr[2:0]];
  end

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (data_valid === 1'b1) begin
      n_valid++;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_valid: got data %0h, expected no valid word (t=%0t)", dout, $time);
      end else begin
        chk("pop_data", int'(dout), int'(exp_q.pop_front()));
      end
    end
  end

  task automatic drive(input logic p, input logic q, input logic [9:0] d);
    @(negedge clk);
    push = p;
    pop  = q;
    din  = d;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    push  = 1'b0;
    pop   = 1'b0;
    reset = 1'b1;
    #2;
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    push  = 1'b0;
    pop   = 1'b0;
    din   = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_count", int'(count), 0);
    chk("rst_empty", int'(empty), 1);
    chk("rst_aempty", int'(almost_empty), 1);
    chk("rst_full", int'(full), 0);
    chk("rst_afull", int'(almost_full), 0);
    chk("rst_error", int'(error), 0);
    chk("rst_valid", int'(data_valid), 0);
    chk("rst_waddr", int'(write_addr), 0);
    chk("rst_raddr", int'(read_addr), 0);
    @(negedge clk);
    reset = 1'b0;

    // fill with 1..8
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, 1'b0, 10'(i));
      chk("fill_we", int'(write_enable), 1);
      chk("fill_waddr", int'(write_addr), i - 1);
      tick();
      chk("fill_count", int'(count), i);
      chk("fill_afull", int'(almost_full), (i >= 6) ? 1 : 0);
      chk("fill_full", int'(full), (i == 8) ? 1 : 0);
      chk("fill_error", int'(error), 0);
    end

    drive(1'b1, 1'b0, 10'h3FF);
    chk("ovf_we", int'(write_enable), 0);
    tick();
    chk("ovf_count", int'(count), 8);
    chk("ovf_error", int'(error), 1);

    // drain 1..8
    for (int i = 1; i <= 8; i++) begin
      drive(1'b0, 1'b1, '0);
      chk("drain_re", int'(read_enable), 1);
      exp_q.push_back(10'(i));
      tick();
      chk("drain_count", int'(count), 8 - i);
      chk("drain_aempty", int'(almost_empty), (8 - i <= 2) ? 1 : 0);
      chk("drain_empty", int'(empty), (i == 8) ? 1 : 0);
      chk("drain_error_sticky", int'(error), 1);
    end
    drive(1'b0, 1'b1, '0);
    chk("udf_re", int'(read_enable), 0);
    tick();
    chk("udf_count", int'(count), 0);
    chk("udf_valid", int'(data_valid), 0);

    // rejected pop sets error from a clean state
    pulse_reset();
    chk("clr_error", int'(error), 0);
    drive(1'b0, 1'b1, '0);
    tick();
    chk("udf_sets_error", int'(error), 1);
    pulse_reset();

    // wrap-around: 5 in / 5 out, then 6 in / 6 out
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b0, 10'h100 + 10'(i));
      tick();
    end
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 1'b1, '0);
      exp_q.push_back(10'h100 + 10'(i));
      tick();
    end
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 1'b0, 10'h140 + 10'(i));
      chk("wrap_waddr", int'(write_addr), (5 + i) % 8);
      tick();
    end
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, 1'b1, '0);
      chk("wrap_raddr", int'(read_addr), (5 + i) % 8);
      exp_q.push_back(10'h140 + 10'(i));
      tick();
    end
    chk("wrap_count", int'(count), 0);
    chk("wrap_error", int'(error), 0);

    // simultaneous push+pop at count 4 (pointers start at 3)
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0, 10'h200 + 10'(i));
      tick();
    end
    chk("sim_count0", int'(count), 4);
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 1'b1, 10'h204 + 10'(i));
      chk("sim_we", int'(write_enable), 1);
      chk("sim_re", int'(read_enable), 1);
      exp_q.push_back(10'h200 + 10'(i));
      tick();
      chk("sim_count", int'(count), 4);
    end
    chk("sim_waddr", int'(write_addr), 1);
    chk("sim_raddr", int'(read_addr), 5);
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b1, '0);
      exp_q.push_back(10'h20A + 10'(i));
      tick();
    end
    chk("sim_drained", int'(count), 0);

    // push+pop while empty: write only, pop rejected
    drive(1'b1, 1'b1, 10'h2AA);
    chk("emp_both_we", int'(write_enable), 1);
    chk("emp_both_re", int'(read_enable), 0);
    tick();
    chk("emp_both_count", int'(count), 1);
    chk("emp_both_error", int'(error), 1);
    pulse_reset();

    // push+pop while full: read only, push rejected
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 1'b0, 10'h300 + 10'(i));
      tick();
    end
    chk("full_again", int'(full), 1);
    drive(1'b1, 1'b1, 10'h3AA);
    chk("full_both_we", int'(write_enable), 0);
    chk("full_both_re", int'(read_enable), 1);
    exp_q.push_back(10'h300);
    tick();
    chk("full_both_count", int'(count), 7);
    chk("full_both_error", int'(error), 1);

    // down to 5, then asynchronous reset mid-cycle
    for (int i = 1; i <= 2; i++) begin
      drive(1'b0, 1'b1, '0);
      exp_q.push_back(10'h300 + 10'(i));
      tick();
    end
    chk("pre_rst_count", int'(count), 5);
    drive(1'b0, 1'b1, '0);
    pop = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    chk("async_count", int'(count), 0);
    chk("async_empty", int'(empty), 1);
    chk("async_error", int'(error), 0);
    chk("async_valid", int'(data_valid), 0);
    chk("async_waddr", int'(write_addr), 0);
    chk("async_raddr", int'(read_addr), 0);
    pop = 1'b1;
    #1;
    chk("async_re", int'(read_enable), 0);
    reset = 1'b0;
    tick();
    chk("post_rst_count", int'(count), 0);
    chk("post_rst_error", int'(error), 1);
    drive(1'b0, 1'b0, '0);
    tick();
    chk("post_rst_valid", int'(data_valid), 0);

    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    chk("sb_leftover", exp_q.size(), 0);
    chk("valid_total", n_valid, 36);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
